// File: rtl/instr_prefetch_queue.sv
// Instruction fetch stage: owns the fetch PC, keeps one request in flight to a
// variable-latency instruction memory and queues {pc, instr} pairs for the core.
module instr_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   target_q, target_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_post;
  entry_t        mem_q [DEPTH];

  logic [31:0] redir_pc_al;
  logic        push, pop;

  assign redir_pc_al = redirect_pc & ~32'h3;

  // A redirect kills the head in the same cycle so no stale instruction is accepted.
  assign inst_valid = (count_q != '0) && !redirect;
  assign pop        = inst_valid && inst_ready;
  assign push       = (state_q == WAIT) && imem_ack && !redirect;
  assign count_post = count_q + CW'(push) - CW'(pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output is assigned a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (!redirect && count_q < DEPTH_C) state_d = WAIT;
      WAIT: begin
        if (imem_ack) state_d = (redirect || count_post < DEPTH_C) ? WAIT : IDLE;
        else if (redirect) state_d = DROP;
      end
      DROP: if (imem_ack) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q != IDLE);
    imem_addr = addr_q;
  end

  // Fetch PC, request address and the pending redirect target.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    target_d   = target_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) fetch_pc_d = redir_pc_al;
        else if (count_q < DEPTH_C) addr_d = fetch_pc_q;
      end
      WAIT, DROP: begin
        if (imem_ack && redirect) begin
          fetch_pc_d = redir_pc_al;
          addr_d     = redir_pc_al;
        end else if (imem_ack && state_q == WAIT) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          addr_d     = fetch_pc_q + 32'd4;
        end else if (imem_ack) begin
          fetch_pc_d = target_q;
          addr_d     = target_q;
        end else if (redirect) begin
          target_d = redir_pc_al;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      target_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      target_q   <= target_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_post;
    end
  end

  // NOTE: the storage array has no reset; count_q gates every read, so its
  // contents are never observed before being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: fetch_pc_q, data: imem_rdata};
  end

  assign inst_out = inst_valid ? mem_q[rd_ptr_q].data : '0;
  assign inst_pc  = inst_valid ? mem_q[rd_ptr_q].pc   : '0;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Randomized bench for instr_prefetch_queue: a behavioural memory plus an
// in-order PC stream model check every fetch request and every delivered instruction.
module tb_instr_prefetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_valid (inst_valid),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model state
  logic        pend = 1'b0;
  int          lat_left = 0;
  logic [31:0] held_addr = '0;

  // Stream model: next PC the core must see, next address a fresh request must use
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_fetch = RESET_PC;
  int          n_deliv = 0;

  // Per-cycle observations
  logic        s_req, s_valid, s_start, s_ack, s_deliv;
  logic [31:0] s_addr, s_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: memory responds, inputs are driven at the falling edge, outputs
  // sampled 1ns later and the handshake that the next rising edge will perform
  // is applied to the model.
  task automatic tick(input logic rdy, input logic redir, input logic [31:0] tgt, input int lat);
    logic ack;
    @(posedge clk);
    @(negedge clk);
    ack     = 1'b0;
    s_start = 1'b0;
    if (imem_req) begin
      if (!pend) begin
        pend      = 1'b1;
        s_start   = 1'b1;
        lat_left  = (lat < 0) ? int'($urandom_range(3)) : lat;
        held_addr = imem_addr;
        check("fetch_addr", imem_addr, exp_fetch);
        exp_fetch = exp_fetch + 32'd4;
      end else begin
        check("addr_stable", imem_addr, held_addr);
      end
      if (lat_left == 0) begin
        ack  = 1'b1;
        pend = 1'b0;
      end else begin
        lat_left--;
      end
    end else if (pend) begin
      check("req_held", 32'(imem_req), 32'd1);
      pend = 1'b0;
    end
    imem_ack    = ack;
    imem_rdata  = ack ? (held_addr ^ XOR_KEY) : $urandom;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = tgt;
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = inst_valid;
    s_ack   = ack;
    s_pc    = inst_pc;
    s_deliv = 1'b0;
    if (redir) begin
      check("valid_on_redirect", 32'(inst_valid), 32'd0);
      exp_pc    = tgt & ~32'h3;
      exp_fetch = tgt & ~32'h3;
    end else if (inst_valid && rdy) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_out", inst_out, exp_pc ^ XOR_KEY);
      exp_pc  = exp_pc + 32'd4;
      s_deliv = 1'b1;
      n_deliv++;
    end
    if (!inst_valid) begin
      check("out_idle_zero", inst_out, 32'd0);
      check("pc_idle_zero", inst_pc, 32'd0);
    end
  endtask

  // Reset pulse with an ack arriving during reset, which must be ignored.
  task automatic do_reset();
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = $urandom;
    redirect   = 1'b0;
    inst_ready = 1'b1;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_out", inst_out, 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    imem_ack  = 1'b0;
    pend      = 1'b0;
    exp_pc    = RESET_PC;
    exp_fetch = RESET_PC;
  endtask

  initial begin
    int d0;
    logic found;

    // Zero-wait memory: first request right after reset, one instruction per cycle
    do_reset();
    tick(1'b1, 1'b0, '0, 0);
    check("first_req", 32'(s_req), 32'd1);
    check("first_addr", s_addr, RESET_PC);
    check("empty_before_ack", 32'(s_valid), 32'd0);
    tick(1'b1, 1'b0, '0, 0);
    check("valid_after_ack", 32'(s_valid), 32'd1);
    d0 = n_deliv;
    repeat (20) tick(1'b1, 1'b0, '0, 0);
    check("throughput", 32'(n_deliv - d0), 32'd20);

    // Stalled core, latency 2: queue fills to 4 and fetch stops
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(1'b0, 1'b0, '0, 2);
      if (i >= 13) check("full_req_low", 32'(s_req), 32'd0);
    end
    check("full_valid", 32'(s_valid), 32'd1);
    check("full_queued", exp_fetch - exp_pc, 32'd16);
    d0 = n_deliv;
    repeat (4) tick(1'b1, 1'b0, '0, 2);
    check("drain_count", 32'(n_deliv - d0), 32'd4);
    repeat (8) tick(1'b1, 1'b0, '0, 2);

    // Latency 3, redirect one cycle after the request for 0x8 is issued
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1'b1, 1'b0, '0, 3);
      found = s_start && (s_addr == 32'h8);
    end
    check("found_req_8", 32'(found), 32'd1);
    tick(1'b1, 1'b1, 32'h0000_0100, 3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, '0, 3);
      if (s_deliv) begin
        found = 1'b1;
        check("first_redir_pc", s_pc, 32'h0000_0100);
      end
    end
    check("redir_delivered", 32'(found), 32'd1);

    // Redirect in the same cycle as an ack
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, '0, 2);
      found = s_start;
    end
    check("found_start", 32'(found), 32'd1);
    tick(1'b1, 1'b0, '0, 2);
    tick(1'b1, 1'b1, 32'h0000_0202, 2);
    check("ack_with_redirect", 32'(s_ack), 32'd1);
    tick(1'b1, 1'b0, '0, 2);
    check("redir_req", 32'(s_req), 32'd1);
    check("redir_addr", s_addr, 32'h0000_0200);
    check("redir_wait0", 32'(s_valid), 32'd0);
    tick(1'b1, 1'b0, '0, 2);
    check("redir_wait1", 32'(s_valid), 32'd0);
    tick(1'b1, 1'b0, '0, 2);
    check("redir_wait_ack", 32'(s_valid), 32'd0);
    tick(1'b1, 1'b0, '0, 2);
    check("redir_valid", 32'(s_valid), 32'd1);
    check("redir_head_pc", s_pc, 32'h0000_0200);

    // Reset while a stale response is pending
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b1, 1'b0, '0, 3);
      found = s_start;
    end
    check("found_start_drop", 32'(found), 32'd1);
    tick(1'b1, 1'b1, 32'h0000_0300, 3);
    do_reset();
    tick(1'b1, 1'b0, '0, 1);
    check("restart_req", 32'(s_req), 32'd1);
    check("restart_addr", s_addr, RESET_PC);
    repeat (10) tick(1'b1, 1'b0, '0, 1);

    // Randomized traffic, including redirects near the top of the address space
    d0 = n_deliv;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(7) == 0) ? (32'hFFFF_FFF4 | 32'($urandom_range(3))) : $urandom;
      tick(($urandom_range(3) != 0), ($urandom_range(19) == 0), tgt, -1);
    end
    check("random_progress", 32'(n_deliv - d0 > 300), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
